// File: rtl/bif_bctl_cycle.sv
// Bus-cycle sequencer behind the BIF sync registers: grant, transfer tracking,
// slave timeout, refresh interleave and sticky parity-error flag.
module bif_bctl_cycle #(
    parameter int TOUT_CYCLES = 63,
    parameter int REF_CYCLES  = 4
) (
    input  logic OSC,
    input  logic CLEAR,
    input  logic MR_n,
    input  logic BREQ50_n,
    input  logic BDAP50_n,
    input  logic BINPUT50_n,
    input  logic BDRY25_n,
    input  logic BDRY50_n,
    input  logic BDRY75_n,
    input  logic BPERR50_n,
    input  logic REFRQ50_n,
    input  logic BLOCK25_n,
    input  logic PERRCLR,
    output logic BGNT_n,
    output logic BACT_n,
    output logic RFACT_n,
    output logic BDLAT,
    output logic BWDONE,
    output logic BTOUT,
    output logic PERR
);

    typedef enum logic [2:0] {
        IDLE, REFRESH, GRANT, ADDR, WAITDRY, DONE
    } state_t;

    localparam logic [7:0] TOUT_LIM = 8'(TOUT_CYCLES);
    localparam logic [3:0] REF_LOAD = 4'(REF_CYCLES - 1);

    state_t     state;
    logic       refPrev;
    logic       refPend;
    logic       dirRd;
    logic       doneFirst;
    logic [7:0] toutCnt;
    logic [3:0] refCnt;

    logic refFall;
    logic dryEdge;
    logic toutHit;
    logic perrSet;

    always_comb begin
        refFall = refPrev & ~REFRQ50_n;
        dryEdge = ~BDRY50_n & BDRY75_n;
        toutHit = (toutCnt == TOUT_LIM);
        perrSet = ~BPERR50_n &
                  ((state == WAITDRY) || ((state == DONE) && doneFirst));
    end

    always_ff @(posedge OSC or posedge CLEAR) begin
        if (CLEAR) begin
            state     <= IDLE;
            refPrev   <= 1'b1;
            refPend   <= 1'b0;
            dirRd     <= 1'b0;
            doneFirst <= 1'b0;
            toutCnt   <= '0;
            refCnt    <= '0;
            BGNT_n    <= 1'b1;
            BACT_n    <= 1'b1;
            RFACT_n   <= 1'b1;
            BDLAT     <= 1'b0;
            BWDONE    <= 1'b0;
            BTOUT     <= 1'b0;
            PERR      <= 1'b0;
        end else begin
            refPrev <= REFRQ50_n;
            BDLAT   <= 1'b0;
            BWDONE  <= 1'b0;
            BTOUT   <= 1'b0;
            // PERR survives MR_n; a new error beats a same-cycle clear
            if (perrSet)
                PERR <= 1'b1;
            else if (PERRCLR)
                PERR <= 1'b0;

            if (!MR_n) begin
                state     <= IDLE;
                refPend   <= 1'b0;
                dirRd     <= 1'b0;
                doneFirst <= 1'b0;
                toutCnt   <= '0;
                refCnt    <= '0;
                BGNT_n    <= 1'b1;
                BACT_n    <= 1'b1;
                RFACT_n   <= 1'b1;
            end else begin
                refPend   <= refPend | refFall;
                doneFirst <= 1'b0;
                unique case (state)
                    IDLE: begin
                        if (refPend) begin
                            state   <= REFRESH;
                            RFACT_n <= 1'b0;
                            refCnt  <= REF_LOAD;
                            refPend <= refFall;
                        end else if (!BREQ50_n && BLOCK25_n) begin
                            state   <= GRANT;
                            BGNT_n  <= 1'b0;
                            toutCnt <= '0;
                        end
                    end
                    REFRESH: begin
                        if (refCnt == 4'd0) begin
                            state   <= IDLE;
                            RFACT_n <= 1'b1;
                        end else begin
                            refCnt <= refCnt - 4'd1;
                        end
                    end
                    GRANT: begin
                        toutCnt <= toutCnt + 8'd1;
                        if (!BDAP50_n) begin
                            state <= ADDR;
                        end else if (BREQ50_n) begin
                            state  <= IDLE;
                            BGNT_n <= 1'b1;
                        end else if (toutHit) begin
                            state     <= DONE;
                            BTOUT     <= 1'b1;
                            doneFirst <= 1'b1;
                        end
                    end
                    ADDR: begin
                        toutCnt <= toutCnt + 8'd1;
                        dirRd   <= ~BINPUT50_n;
                        state   <= WAITDRY;
                        BACT_n  <= 1'b0;
                    end
                    WAITDRY: begin
                        toutCnt <= toutCnt + 8'd1;
                        if (dryEdge) begin
                            state     <= DONE;
                            BACT_n    <= 1'b1;
                            doneFirst <= 1'b1;
                            BDLAT     <= dirRd;
                            BWDONE    <= ~dirRd;
                        end else if (toutHit) begin
                            state     <= DONE;
                            BACT_n    <= 1'b1;
                            doneFirst <= 1'b1;
                            BTOUT     <= 1'b1;
                        end
                    end
                    DONE: begin
                        // wait for master and slave to both let go
                        if (BREQ50_n && BDRY25_n) begin
                            state  <= IDLE;
                            BGNT_n <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/bif_bctl_cycle.md
# bif_bctl_cycle

Bus-cycle sequencer directly downstream of the BIF sync registers. It consumes the OSC-synchronised bus handshake signals (`BREQ50_n`, `BDAP50_n`, `BDRY25/50/75_n`, `BINPUT50_n`, `BPERR50_n`, `REFRQ50_n`, `BLOCK25_n`, `MR_n`). From them it grants the bus, tracks one transfer to its data-ready edge, times out dead slaves, interleaves memory refresh, and flags parity errors.

## Interface
Parameters:
- `TOUT_CYCLES`, default 63: cycles allowed from GRANT entry before timeout. Legal range 1..255.
- `REF_CYCLES`, default 4: length of a refresh slot in cycles. Legal range 1..15.

Ports:
- `OSC` in 1: system clock; all state changes on its rising edge.
- `CLEAR` in 1: reset, asynchronous, active-high.
- `MR_n` in 1: synchronised master reset; when low, forces IDLE on the next edge.
- `BREQ50_n` in 1: bus request.
- `BDAP50_n` in 1: data/address present.
- `BINPUT50_n` in 1: low means a read (input) cycle.
- `BDRY25_n` in 1: data ready, first sync stage.
- `BDRY50_n` in 1: data ready, second sync stage.
- `BDRY75_n` in 1: data ready, third sync stage.
- `BPERR50_n` in 1: bus parity error.
- `REFRQ50_n` in 1: refresh request.
- `BLOCK25_n` in 1: low blocks new bus grants.
- `PERRCLR` in 1: one-cycle clear of the `PERR` flag.
- `BGNT_n` out 1: bus grant.
- `BACT_n` out 1: transfer active.
- `RFACT_n` out 1: refresh slot active.
- `BDLAT` out 1: one-cycle strobe that latches read data.
- `BWDONE` out 1: one-cycle strobe marking write complete.
- `BTOUT` out 1: one-cycle bus-timeout strobe.
- `PERR` out 1: sticky parity-error flag.

## Operation
- All outputs are registered.
- Reset values: `BGNT_n`=1, `BACT_n`=1, `RFACT_n`=1, `BDLAT`=0, `BWDONE`=0, `BTOUT`=0, `PERR`=0. State is IDLE, `ref_pend`=0, timeout counter=0.
- States: IDLE, REFRESH, GRANT, ADDR, WAITDRY, DONE.
- `ref_pend`:
  - Set on a falling edge of `REFRQ50_n` (previous sample 1, current sample 0), in any state.
  - Cleared on entering REFRESH. Set wins if both happen on the same cycle.
- IDLE:
  - If `ref_pend` → REFRESH. Refresh has priority over a bus request.
  - Otherwise, if `BREQ50_n`=0 and `BLOCK25_n`=1 → GRANT.
- REFRESH:
  - `RFACT_n`=0 for exactly `REF_CYCLES` cycles (4-bit down-counter), then → IDLE.
  - `BLOCK25_n` does not affect refresh.
- GRANT:
  - `BGNT_n`=0. Timeout counter is cleared on entry and increments every cycle in GRANT, ADDR and WAITDRY.
  - `BDAP50_n`=0 → ADDR.
  - Else `BREQ50_n`=1 → IDLE (request abandoned, no strobe).
  - Else counter==`TOUT_CYCLES` → DONE with `BTOUT`.
- ADDR: one cycle. Captures `dir_rd` = ~`BINPUT50_n`, then → WAITDRY.
- WAITDRY:
  - `BACT_n`=0.
  - Data-ready edge is `BDRY50_n`=0 and `BDRY75_n`=1. On the edge → DONE with `BDLAT` (if `dir_rd`) or `BWDONE` (if not).
  - Else counter==`TOUT_CYCLES` → DONE with `BTOUT`. The edge wins over timeout on the same cycle.
- DONE:
  - `BGNT_n` stays 0, `BACT_n`=1.
  - Stays until `BREQ50_n`=1 and `BDRY25_n`=1 (both master and slave released), then → IDLE.
- Strobes (`BDLAT`, `BWDONE`, `BTOUT`): high only in the first DONE cycle. They are mutually exclusive.
- `PERR`:
  - Set when `BPERR50_n`=0 in WAITDRY or in the first DONE cycle.
  - Cleared by `PERRCLR`. Set wins over clear on the same cycle.
  - Unaffected by `MR_n`; cleared only by `CLEAR` or `PERRCLR`.
- `MR_n`=0, from any state: next state IDLE, all outputs except `PERR` return to their reset values, `ref_pend` and counters cleared. Takes priority over every other transition.
- `CLEAR` mid-cycle: all outputs return to reset values immediately (asynchronous). Nothing from the abandoned cycle is remembered.

## Timing
- Grant latency: IDLE samples `BREQ50_n`=0 at edge N → `BGNT_n`=0 after edge N.
- ADDR: follows the GRANT cycle in which `BDAP50_n`=0 is sampled. WAITDRY follows one cycle later.
- Data edge: edge sampled at edge M in WAITDRY → strobe and DONE are visible after M, and last one cycle.
- Timeout: counter reads 0 in the first GRANT cycle, so `BTOUT` appears `TOUT_CYCLES`+1 edges after GRANT entry if no progress is made.
- Refresh: `RFACT_n` is low for exactly `REF_CYCLES` consecutive cycles. One IDLE cycle always separates REFRESH from the following GRANT.
- A request held through DONE → IDLE does not re-grant until `BREQ50_n` has been seen high. The DONE exit condition guarantees this.

## Test plan
- **Read cycle.** `BREQ50_n`=0, `BDAP50_n`=0 two cycles later, `BINPUT50_n`=0, BDRY pipeline goes low → `BGNT_n` low 1 cycle after request, `BACT_n` low from WAITDRY, single `BDLAT` pulse, `BWDONE`=0. Release both → IDLE with `BGNT_n`=1.
- **Write cycle.** Same as read with `BINPUT50_n`=1 → single `BWDONE` pulse, `BDLAT`=0.
- **Timeout.** `TOUT_CYCLES`=10, no BDRY → `BTOUT` for exactly 1 cycle, 11 edges after GRANT entry. `BACT_n` rises with `BTOUT`.
- **Refresh arbitration.** `REFRQ50_n` falls during an active read → refresh deferred until IDLE. Then `RFACT_n` low for 4 cycles, before a simultaneously pending `BREQ50_n` is granted. `BLOCK25_n`=0 prevents GRANT but not REFRESH.
- **Parity flag.** `BPERR50_n`=0 in WAITDRY → `PERR`=1 and it persists. `PERRCLR` plus a new error on the same cycle → stays 1. `PERRCLR` alone → 0. `MR_n` pulse → `PERR` unchanged.
- **Reset mid-cycle.** `CLEAR` pulsed in WAITDRY → outputs at reset values before the next edge. `MR_n`=0 in GRANT → IDLE next edge, no strobe.
